// File: rtl/nn_ctrl_pkg.sv
// Shared controller types for the NN datapath: sequencer state encoding,
// index-width helper and the MAC accumulator latency.
package nn_ctrl_pkg;

  localparam int MAC_ACC_LATENCY = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  // Index width for n positions, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/index_wrap_counter.sv
// Modulo-MAX index counter: clear wins over en; wrap flags the MAX-1 -> 0 step.
// Ports: clock, reset_n, en, clear in; wrap, index out.
module index_wrap_counter
  import nn_ctrl_pkg::*;
#(
  parameter int  MAX = 4,
  localparam int W   = idx_w(MAX)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clear,
  output logic         wrap,
  output logic [W-1:0] index
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign wrap = en && (index == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      index <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (en) begin
      index <= wrap ? '0 : index + W'(1);
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Row-major weight/input address sequencer for one FC layer with MAC enable alignment.
// Ports: clock, reset_n, start, stall in; busy, done, indices, addr, MAC and result strobes out.
module layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int  NUM_COLS    = 3,
  parameter int  NUM_ROWS    = 4,
  parameter int  MEM_LATENCY = 1,
  localparam int COL_W       = idx_w(NUM_COLS),
  localparam int ROW_W       = idx_w(NUM_ROWS),
  localparam int ADDR_W      = idx_w(NUM_ROWS * NUM_COLS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [COL_W-1:0]  col_index,
  output logic [ROW_W-1:0]  row_index,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              addr_valid,
  output logic              mac_en,
  output logic              acc_clear,
  output logic              result_we,
  output logic [ROW_W-1:0]  result_addr
);

  localparam int DW = idx_w(MEM_LATENCY + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MEM_LATENCY);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [ROW_W-1:0] row;
  } issue_t;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
  } wr_t;

  seq_state_e state;
  seq_state_e state_nxt;

  logic          hold;
  logic          adv;
  logic          issue;
  logic          cnt_clr;
  logic          col_wrap;
  logic          row_wrap;
  logic [DW-1:0] drain_cnt;
  logic          drain_end;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  issue_t head;
  issue_t pipe [MEM_LATENCY];
  wr_t    wr_in;
  wr_t    wrq [MAC_ACC_LATENCY];

  // Stall only bites while a layer is in flight.
  assign hold    = stall && (state == S_RUN || state == S_DRAIN);
  assign adv     = !hold;
  assign issue   = (state == S_RUN) && !stall;
  assign cnt_clr = (state == S_IDLE);

  index_wrap_counter #(.MAX(NUM_COLS)) u_col (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (issue),
    .clear   (cnt_clr),
    .wrap    (col_wrap),
    .index   (col)
  );

  index_wrap_counter #(.MAX(NUM_ROWS)) u_row (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (col_wrap),
    .clear   (cnt_clr),
    .wrap    (row_wrap),
    .index   (row)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drain_cnt <= '0;
    end else if (state != S_DRAIN) begin
      drain_cnt <= '0;
    end else if (adv) begin
      drain_cnt <= drain_cnt + DW'(1);
    end
  end

  assign drain_end = (state == S_DRAIN) && adv &&
                     (drain_cnt == DRAIN_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (row_wrap) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    head.valid = issue;
    head.first = (col == '0);
    head.last  = (col == COL_LAST);
    head.row   = row;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else if (adv) begin
      pipe[0] <= head;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // The accumulator holds a row's sum one stage after its last MAC.
  always_comb begin
    wr_in.valid = pipe[MEM_LATENCY-1].valid &&
                  pipe[MEM_LATENCY-1].last;
    wr_in.row   = pipe[MEM_LATENCY-1].row;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAC_ACC_LATENCY; i++) begin
        wrq[i] <= '0;
      end
    end else if (adv) begin
      wrq[0] <= wr_in;
      for (int i = 1; i < MAC_ACC_LATENCY; i++) begin
        wrq[i] <= wrq[i-1];
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign col_index   = col;
  assign row_index   = row;
  assign weight_addr = ADDR_W'(row) * ADDR_W'(NUM_COLS) +
                       ADDR_W'(col);
  assign addr_valid  = issue;
  assign mac_en      = pipe[MEM_LATENCY-1].valid && adv;
  assign acc_clear   = mac_en && pipe[MEM_LATENCY-1].first;
  assign result_we   = wrq[MAC_ACC_LATENCY-1].valid && adv;
  assign result_addr = wrq[MAC_ACC_LATENCY-1].row;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: default 3x4/L=1 build plus a 1x2/L=3 build.
// Per-cycle vector tables plus hand sequences for reset and stall-at-start.
module tb_layer_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_a, stall_a, busy_a, done_a;
  logic [1:0] col_a, row_a, ra_a;
  logic [3:0] wa_a;
  logic       av_a, mac_a, clr_a, we_a;

  logic       start_b, stall_b, busy_b, done_b;
  logic       col_b, row_b, ra_b, wa_b;
  logic       av_b, mac_b, clr_b, we_b;

  layer_sequencer u_a (
    .clock       (clk),
    .reset_n     (rst_n),
    .start       (start_a),
    .stall       (stall_a),
    .busy        (busy_a),
    .done        (done_a),
    .col_index   (col_a),
    .row_index   (row_a),
    .weight_addr (wa_a),
    .addr_valid  (av_a),
    .mac_en      (mac_a),
    .acc_clear   (clr_a),
    .result_we   (we_a),
    .result_addr (ra_a)
  );

  layer_sequencer #(
    .NUM_COLS    (1),
    .NUM_ROWS    (2),
    .MEM_LATENCY (3)
  ) u_b (
    .clock       (clk),
    .reset_n     (rst_n),
    .start       (start_b),
    .stall       (stall_b),
    .busy        (busy_b),
    .done        (done_b),
    .col_index   (col_b),
    .row_index   (row_b),
    .weight_addr (wa_b),
    .addr_valid  (av_b),
    .mac_en      (mac_b),
    .acc_clear   (clr_b),
    .result_we   (we_b),
    .result_addr (ra_b)
  );

  typedef struct packed {
    logic       st, sl, busy, done, av;
    logic [3:0] wa;
    logic       wchk, mac, clr, we;
    logic [1:0] ra;
  } vec_t;

  typedef struct packed {
    logic       busy, done, av;
    logic [3:0] wa;
    logic       mac, clr, we;
    logic [1:0] ra;
  } obs_t;

  vec_t tbl [3][32];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(
    input logic st, sl, busy, done, av,
    input int wa,
    input logic wchk, mac, clr, we,
    input int ra);
    vec_t v;
    v.st = st; v.sl = sl; v.busy = busy; v.done = done; v.av = av;
    v.wa = 4'(wa); v.wchk = wchk; v.mac = mac; v.clr = clr;
    v.we = we; v.ra = 2'(ra);
    return v;
  endfunction

  function automatic obs_t samp(input bit b);
    obs_t o;
    if (!b) begin
      o.busy = busy_a; o.done = done_a; o.av = av_a; o.wa = wa_a;
      o.mac = mac_a; o.clr = clr_a; o.we = we_a; o.ra = ra_a;
    end else begin
      o.busy = busy_b; o.done = done_b; o.av = av_b;
      o.wa = {3'b0, wa_b}; o.mac = mac_b; o.clr = clr_b;
      o.we = we_b; o.ra = {1'b0, ra_b};
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int c,
                     input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, c, act, exp);
    end
  endtask

  // Entered just after the edge that sampled start; cycle c follows edge c-1.
  task automatic run_table(input int id, input int n, input bit b);
    vec_t e;
    obs_t o;
    string p;
    p = $sformatf("t%0d", id);
    for (int c = 1; c <= n; c++) begin
      e = tbl[id][c];
      #1;
      if (!b) begin start_a = e.st; stall_a = e.sl; end
      else begin start_b = e.st; stall_b = e.sl; end
      @(negedge clk);
      o = samp(b);
      chk({p, ".busy"}, c, int'(o.busy), int'(e.busy));
      chk({p, ".done"}, c, int'(o.done), int'(e.done));
      chk({p, ".addr_valid"}, c, int'(o.av), int'(e.av));
      chk({p, ".mac_en"}, c, int'(o.mac), int'(e.mac));
      chk({p, ".acc_clear"}, c, int'(o.clr), int'(e.clr));
      chk({p, ".result_we"}, c, int'(o.we), int'(e.we));
      if (e.av || e.wchk)
        chk({p, ".weight_addr"}, c, int'(o.wa), int'(e.wa));
      if (e.we)
        chk({p, ".result_addr"}, c, int'(o.ra), int'(e.ra));
      if (b)
        chk({p, ".col_index"}, c, int'(col_b), 0);
      @(posedge clk);
    end
    start_a = 1'b0; stall_a = 1'b0;
    start_b = 1'b0; stall_b = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".busy"}, 0, int'(busy_a), 0);
    chk({nm, ".done"}, 0, int'(done_a), 0);
    chk({nm, ".col"}, 0, int'(col_a), 0);
    chk({nm, ".row"}, 0, int'(row_a), 0);
    chk({nm, ".addr"}, 0, int'(wa_a), 0);
    chk({nm, ".addr_valid"}, 0, int'(av_a), 0);
    chk({nm, ".mac_en"}, 0, int'(mac_a), 0);
    chk({nm, ".acc_clear"}, 0, int'(clr_a), 0);
    chk({nm, ".result_we"}, 0, int'(we_a), 0);
    chk({nm, ".result_addr"}, 0, int'(ra_a), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    // A: defaults, start also pulsed on 3 and 15 (ignored) and 16 (new layer)
    tbl[0][1]  = mk(0,0,1,0,1, 0,0,0,0,0,0);
    tbl[0][2]  = mk(0,0,1,0,1, 1,0,1,1,0,0);
    tbl[0][3]  = mk(1,0,1,0,1, 2,0,1,0,0,0);
    tbl[0][4]  = mk(0,0,1,0,1, 3,0,1,0,0,0);
    tbl[0][5]  = mk(0,0,1,0,1, 4,0,1,1,1,0);
    tbl[0][6]  = mk(0,0,1,0,1, 5,0,1,0,0,0);
    tbl[0][7]  = mk(0,0,1,0,1, 6,0,1,0,0,0);
    tbl[0][8]  = mk(0,0,1,0,1, 7,0,1,1,1,1);
    tbl[0][9]  = mk(0,0,1,0,1, 8,0,1,0,0,0);
    tbl[0][10] = mk(0,0,1,0,1, 9,0,1,0,0,0);
    tbl[0][11] = mk(0,0,1,0,1,10,0,1,1,1,2);
    tbl[0][12] = mk(0,0,1,0,1,11,0,1,0,0,0);
    tbl[0][13] = mk(0,0,1,0,0, 0,0,1,0,0,0);
    tbl[0][14] = mk(0,0,1,0,0, 0,0,0,0,1,3);
    tbl[0][15] = mk(1,0,1,1,0, 0,0,0,0,0,0);
    tbl[0][16] = mk(1,0,0,0,0, 0,0,0,0,0,0);
    tbl[0][17] = mk(0,0,1,0,1, 0,0,0,0,0,0);
    // B: stall high on cycles 4-6
    tbl[1][1]  = mk(0,0,1,0,1, 0,0,0,0,0,0);
    tbl[1][2]  = mk(0,0,1,0,1, 1,0,1,1,0,0);
    tbl[1][3]  = mk(0,0,1,0,1, 2,0,1,0,0,0);
    tbl[1][4]  = mk(0,1,1,0,0, 3,1,0,0,0,0);
    tbl[1][5]  = mk(0,1,1,0,0, 3,1,0,0,0,0);
    tbl[1][6]  = mk(0,1,1,0,0, 3,1,0,0,0,0);
    tbl[1][7]  = mk(0,0,1,0,1, 3,0,1,0,0,0);
    tbl[1][8]  = mk(0,0,1,0,1, 4,0,1,1,1,0);
    tbl[1][9]  = mk(0,0,1,0,1, 5,0,1,0,0,0);
    tbl[1][10] = mk(0,0,1,0,1, 6,0,1,0,0,0);
    tbl[1][11] = mk(0,0,1,0,1, 7,0,1,1,1,1);
    tbl[1][12] = mk(0,0,1,0,1, 8,0,1,0,0,0);
    tbl[1][13] = mk(0,0,1,0,1, 9,0,1,0,0,0);
    tbl[1][14] = mk(0,0,1,0,1,10,0,1,1,1,2);
    tbl[1][15] = mk(0,0,1,0,1,11,0,1,0,0,0);
    tbl[1][16] = mk(0,0,1,0,0, 0,0,1,0,0,0);
    tbl[1][17] = mk(0,0,1,0,0, 0,0,0,0,1,3);
    tbl[1][18] = mk(0,0,1,1,0, 0,0,0,0,0,0);
    tbl[1][19] = mk(0,0,0,0,0, 0,0,0,0,0,0);
    // C: 1 column, 2 rows, latency 3
    tbl[2][1]  = mk(0,0,1,0,1, 0,0,0,0,0,0);
    tbl[2][2]  = mk(0,0,1,0,1, 1,0,0,0,0,0);
    tbl[2][3]  = mk(0,0,1,0,0, 0,0,0,0,0,0);
    tbl[2][4]  = mk(0,0,1,0,0, 0,0,1,1,0,0);
    tbl[2][5]  = mk(0,0,1,0,0, 0,0,1,1,1,0);
    tbl[2][6]  = mk(0,0,1,0,0, 0,0,0,0,1,1);
    tbl[2][7]  = mk(0,0,1,1,0, 0,0,0,0,0,0);
    tbl[2][8]  = mk(0,0,0,0,0, 0,0,0,0,0,0);

    rst_n = 1'b0;
    start_a = 1'b0; stall_a = 1'b0;
    start_b = 1'b0; stall_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    chk("rst.b_busy", 0, int'(busy_b), 0);
    rst_n = 1'b1;
    @(posedge clk);

    #1 start_a = 1'b1;
    @(posedge clk);
    run_table(0, 17, 1'b0);

    // Second layer from A is in its cycle 2; reset async in its cycle 7.
    repeat (5) @(posedge clk);
    #1;
    chk("r.pre_av", 7, int'(av_a), 1);
    chk("r.pre_addr", 7, int'(wa_a), 6);
    rst_n = 1'b0;
    #1 chk_zero("r.async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    chk("r.c1_av", 1, int'(av_a), 1);
    chk("r.c1_addr", 1, int'(wa_a), 0);
    chk("r.c1_mac", 1, int'(mac_a), 0);
    @(posedge clk);
    #1;
    chk("r.c2_addr", 2, int'(wa_a), 1);
    chk("r.c2_clr", 2, int'(clr_a), 1);
    do_reset();

    #1 start_a = 1'b1;
    @(posedge clk);
    run_table(1, 19, 1'b0);

    // D: stall held with start in IDLE, dropped on cycle 3
    #1 start_a = 1'b1; stall_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    chk("d.c1_busy", 1, int'(busy_a), 1);
    chk("d.c1_av", 1, int'(av_a), 0);
    @(posedge clk);
    #1;
    chk("d.c2_av", 2, int'(av_a), 0);
    chk("d.c2_addr", 2, int'(wa_a), 0);
    @(posedge clk);
    #1 stall_a = 1'b0;
    #1;
    chk("d.c3_av", 3, int'(av_a), 1);
    chk("d.c3_addr", 3, int'(wa_a), 0);
    dc = 0;
    for (int c = 3; c < 40 && dc == 0; c++) begin
      if (c > 3) begin
        @(posedge clk);
        #2;
      end
      if (done_a) dc = c;
    end
    chk("d.done_cycle", 0, dc, 17);
    do_reset();

    #1 start_b = 1'b1;
    @(posedge clk);
    run_table(2, 8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
